// File: rtl/mem_arb_pkg.sv
// Shared types and widths for the memory-bank arbiter.
// The bank geometry lives here so the arbiter and its users agree on port widths.
package mem_arb_pkg;

  localparam int MEM_NUM_REQ     = 4;
  localparam int BANK_ADDR_WIDTH = 8;
  localparam int COL_ADDR_WIDTH  = 4;
  localparam int TX_DATA_WIDTH   = 16;

  typedef struct packed {
    logic                       we;
    logic                       re;
    logic [BANK_ADDR_WIDTH-1:0] row;
    logic [COL_ADDR_WIDTH-1:0]  col;
    logic [TX_DATA_WIDTH-1:0]   data;
  } mem_req_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter_rr_picker.sv
// Combinational round-robin picker: first eligible request after ptr, wrapping.
// Exclusive mode masks every requester except excl_idx.
module rr_picker #(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  input  logic               excl_en,
  input  logic [IDX_W-1:0]   excl_idx,
  output logic               valid,
  output logic [IDX_W-1:0]   idx
);

  logic [NUM_REQ-1:0] elig;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_elig
    assign elig[gi] = req[gi] & (~excl_en | (excl_idx == IDX_W'(gi)));
  end

  // Scan from the farthest offset down so the nearest hit after ptr is the last write.
  always_comb begin
    int cand;
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (elig[cand]) begin
        valid = 1'b1;
        idx   = IDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one mem bank port among NUM_REQ requesters: round-robin grant with
// exclusive-owner override, latched command replay, ack routed only to the owner.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int  NUM_REQ = MEM_NUM_REQ,
  parameter int  CNT_W   = 32,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                                     clock,
  input  logic                                     reset,
  input  logic [NUM_REQ-1:0]                       req_write_en,
  input  logic [NUM_REQ-1:0]                       req_read_en,
  input  logic [NUM_REQ-1:0][BANK_ADDR_WIDTH-1:0]  req_row_addr,
  input  logic [NUM_REQ-1:0][COL_ADDR_WIDTH-1:0]   req_col_addr,
  input  logic [NUM_REQ-1:0][TX_DATA_WIDTH-1:0]    req_partial_vec,
  input  logic                                     excl_en_in,
  input  logic [IDX_W-1:0]                         excl_idx_in,
  output logic [NUM_REQ-1:0]                       req_ack_out,
  output logic [TX_DATA_WIDTH-1:0]                 rd_partial_vec_out,
  output logic                                     mem_write_en,
  output logic                                     mem_read_en,
  output logic [BANK_ADDR_WIDTH-1:0]               mem_row_addr,
  output logic [COL_ADDR_WIDTH-1:0]                mem_col_addr,
  output logic [TX_DATA_WIDTH-1:0]                 mem_partial_vec,
  input  logic                                     mem_ack,
  input  logic                                     mem_busy,
  input  logic [TX_DATA_WIDTH-1:0]                 mem_partial_vec_in,
  output logic                                     grant_valid_out,
  output logic [IDX_W-1:0]                         grant_idx_out,
  output logic [CNT_W-1:0]                         tx_count_out,
  output logic                                     proto_err_out
);

  arb_state_t         state_reg, state_next;
  mem_req_t           lat_reg;
  logic [IDX_W-1:0]   grant_idx_reg;
  logic [CNT_W-1:0]   tx_count_reg;
  logic               proto_err_reg;
  logic [NUM_REQ-1:0] req_vec;
  logic [NUM_REQ-1:0] both_vec;
  logic               pick_valid;
  logic [IDX_W-1:0]   pick_idx;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
    assign req_vec[gi]  = req_write_en[gi] | req_read_en[gi];
    assign both_vec[gi] = req_write_en[gi] & req_read_en[gi];
  end

  // The last owner doubles as the round-robin pointer.
  rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
    .req      (req_vec),
    .ptr      (grant_idx_reg),
    .excl_en  (excl_en_in),
    .excl_idx (excl_idx_in),
    .valid    (pick_valid),
    .idx      (pick_idx)
  );

  always_comb begin
    state_next      = state_reg;
    req_ack_out     = '0;
    mem_write_en    = 1'b0;
    mem_read_en     = 1'b0;
    mem_row_addr    = '0;
    mem_col_addr    = '0;
    mem_partial_vec = '0;
    case (state_reg)
      IDLE: begin
        if (pick_valid) state_next = ISSUE;
      end
      ISSUE: begin
        mem_write_en    = lat_reg.we;
        mem_read_en     = lat_reg.re;
        mem_row_addr    = lat_reg.row;
        mem_col_addr    = lat_reg.col;
        mem_partial_vec = lat_reg.data;
        if (mem_ack) begin
          req_ack_out[grant_idx_reg] = 1'b1;
          state_next                 = DRAIN;
        end
      end
      DRAIN: begin
        req_ack_out[grant_idx_reg] = mem_ack;
        if (!mem_ack && !mem_busy) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg     <= IDLE;
      lat_reg       <= '0;
      grant_idx_reg <= IDX_W'(NUM_REQ - 1);
      tx_count_reg  <= '0;
      proto_err_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      // A requester raising both enables gets a write.
      if (state_reg == IDLE && pick_valid) begin
        lat_reg <= '{we:   req_write_en[pick_idx],
                     re:   req_read_en[pick_idx] & ~req_write_en[pick_idx],
                     row:  req_row_addr[pick_idx],
                     col:  req_col_addr[pick_idx],
                     data: req_partial_vec[pick_idx]};
        grant_idx_reg <= pick_idx;
      end
      if (state_reg == ISSUE && mem_ack) tx_count_reg <= tx_count_reg + CNT_W'(1);
      if (|both_vec) proto_err_reg <= 1'b1;
    end
  end

  assign rd_partial_vec_out = mem_partial_vec_in;
  assign grant_valid_out    = (state_reg != IDLE);
  assign grant_idx_out      = grant_idx_reg;
  assign tx_count_out       = tx_count_reg;
  assign proto_err_out      = proto_err_reg;

endmodule
